// File: rtl/decode_issue_queue.sv
// rtl/decode_issue_queue.sv - fetch-to-decode instruction queue with MIPS dual-issue pairing
// Circular buffer; slot outputs are show-ahead from head, gated by branch/serialise/RAW rules.
module decode_issue_queue #(
  parameter int DEPTH   = 8,
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [FETCH_W-1:0]        in_valid,
  input  logic [32*FETCH_W-1:0]     in_inst,
  input  logic [32*FETCH_W-1:0]     in_pc,
  output logic                      in_ready,
  output logic [ISSUE_W-1:0]        out_valid,
  output logic [32*ISSUE_W-1:0]     out_inst,
  output logic [32*ISSUE_W-1:0]     out_pc,
  input  logic                      out_ready,
  output logic [$clog2(DEPTH):0]    count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]          mem_inst [DEPTH];
  logic [31:0]          mem_pc   [DEPTH];
  logic [PW-1:0]        head, tail, head1;
  logic [CW-1:0]        cnt, push_n, pop_n;
  logic                 push_en;
  logic                 stalled;
  logic [FETCH_W-1:0]   held_valid;
  logic [31:0]          c0, c1;
  logic [4:0]           wr0;
  logic                 br0, br1, solo0, solo1, raw, v0, v1;

  function automatic logic is_br(input logic [31:0] inst);
    logic [5:0] op;
    logic [5:0] fn;
    op = inst[31:26];
    fn = inst[5:0];
    return (op == 6'b000001) || (op[5:1] == 5'b00001) || (op[5:2] == 4'b0001) ||
           (op == 6'b000000 && fn[5:1] == 5'b00100);
  endfunction

  function automatic logic is_solo(input logic [31:0] inst);
    logic [5:0] op;
    logic [5:0] fn;
    op = inst[31:26];
    fn = inst[5:0];
    return (op == 6'b010000) ||
           (op == 6'b000000 && (fn[5:1] == 5'b00110 || fn[5:2] == 4'b0100 || fn[5:3] == 3'b011));
  endfunction

  // Register 0 doubles as "no write", so it never creates a dependency.
  function automatic logic [4:0] wr_reg(input logic [31:0] inst);
    logic [5:0] op;
    op = inst[31:26];
    if (op == 6'b000000) return inst[15:11];
    if (op[5:3] == 3'b001 || op[5:3] == 3'b100) return inst[20:16];
    if (op == 6'b000011) return 5'd31;
    return 5'd0;
  endfunction

  always_comb begin
    in_ready = (cnt <= CW'(DEPTH - FETCH_W));
    push_en  = in_ready && !flush && (|in_valid);
    push_n   = '0;
    for (int i = 0; i < FETCH_W; i++) push_n = push_n + CW'(in_valid[i]);
  end

  assign head1 = head + PW'(1);
  assign c0    = mem_inst[head];
  assign c1    = mem_inst[head1];
  assign br0   = is_br(c0);
  assign br1   = is_br(c1);
  assign solo0 = is_solo(c0);
  assign solo1 = is_solo(c1);
  assign wr0   = wr_reg(c0);
  assign raw   = (wr0 != 5'd0) && (c1[25:21] == wr0 || c1[20:16] == wr0);

  // A branch waits for its delay slot only when the pair can issue together.
  assign v0 = !flush && (cnt != '0) && !(br0 && ISSUE_W == 2 && cnt < CW'(2));
  assign v1 = v0 && (cnt >= CW'(2)) && (br0 || (!solo0 && !solo1 && !br1 && !raw));

  generate
    if (ISSUE_W == 1) begin : g_single
      assign out_valid = v0;
      assign out_inst  = c0;
      assign out_pc    = mem_pc[head];
    end else begin : g_dual
      assign out_valid = {v1, v0};
      assign out_inst  = {c1, c0};
      assign out_pc    = {mem_pc[head1], mem_pc[head]};
    end
  endgenerate

  always_comb begin
    pop_n = '0;
    if (out_ready)
      for (int s = 0; s < ISSUE_W; s++) pop_n = pop_n + CW'(out_valid[s]);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head       <= '0;
      tail       <= '0;
      cnt        <= '0;
      stalled    <= 1'b0;
      held_valid <= '0;
    end else begin
      // Fetch must hold a refused bundle unchanged until it is taken.
      if (stalled) assert (in_valid == held_valid);
      head       <= head + PW'(pop_n);
      if (push_en) tail <= tail + PW'(push_n);
      cnt        <= cnt + (push_en ? push_n : CW'(0)) - pop_n;
      stalled    <= (|in_valid) && !in_ready;
      held_valid <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) begin
      for (int i = 0; i < FETCH_W; i++) begin
        if (in_valid[i]) begin
          mem_inst[tail + PW'(i)] <= in_inst[32*i +: 32];
          mem_pc[tail + PW'(i)]   <= in_pc[32*i +: 32];
        end
      end
    end
  end

  assign count = cnt;
endmodule
